// File: rtl/mc_pi_pkg.sv
// Shared definitions for the Monte Carlo pi estimator datapath.
package mc_pi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Defaults shared with the upstream square/add stage
    localparam int unsigned DEF_SUM_W  = 10;
    localparam int unsigned DEF_THRESH = 256;
    localparam int unsigned DEF_LOG_N  = 8;

    // Fractional bits of the pi estimate (Q2.6)
    localparam int unsigned PI_FRAC = 6;

endpackage

// File: rtl/mc_pi_scale.sv
// Hit count to Q2.6 pi estimate: 4*hits/N in PI_FRAC fractional bits, saturated to 8 bits.
module mc_pi_scale
    import mc_pi_pkg::*;
#(
    parameter int unsigned LOG_N = DEF_LOG_N,
    parameter int unsigned CNT_W = LOG_N + 1
) (
    input  logic [CNT_W-1:0] hits,
    output logic [7:0]       pi_q
);

    // Multiply by 4 (two integer bits) plus the fraction, then divide by N
    localparam int unsigned SHIFT = PI_FRAC + 2;

    logic [CNT_W+7:0] scaled;

    // Shift-and-saturate; hits == N yields 256 which clamps to 255
    always_comb begin
        scaled = ((CNT_W+8)'(hits) << SHIFT) >> LOG_N;
        if (scaled > (CNT_W+8)'(8'hFF)) begin
            pi_q = 8'hFF;
        end else begin
            pi_q = scaled[7:0];
        end
    end

endmodule

// File: rtl/mc_pi_accumulator.sv
// Windowed hit counter for the Monte Carlo pi estimator with registered result.
module mc_pi_accumulator
    import mc_pi_pkg::*;
#(
    parameter int unsigned SUM_W  = DEF_SUM_W,
    parameter int unsigned THRESH = DEF_THRESH,
    parameter int unsigned LOG_N  = DEF_LOG_N,
    parameter int unsigned CNT_W  = LOG_N + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sample_valid,
    input  logic [SUM_W-1:0] sample_sum,
    input  logic             result_ack,
    output logic             busy,
    output logic             result_valid,
    output logic [CNT_W-1:0] result_hits,
    output logic [7:0]       pi_q,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << LOG_N) - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] hit_total;
    logic [7:0]       pi_next;
    logic             is_hit;
    logic             restart;
    logic             accept;
    logic             last;
    logic             ovr_set;

    // Hit classification and running total including the current sample
    always_comb begin
        is_hit    = (32'(sample_sum) < THRESH);
        hit_total = hit_cnt + CNT_W'(is_hit);
    end

    mc_pi_scale #(
        .LOG_N (LOG_N),
        .CNT_W (CNT_W)
    ) u_scale (
        .hits (hit_total),
        .pi_q (pi_next)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_next = state;
        restart    = 1'b0;
        accept     = 1'b0;
        last       = 1'b0;
        ovr_set    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    restart    = 1'b1;
                end else if (sample_valid) begin
                    ovr_set = 1'b1;
                end
            end
            RUN: begin
                if (start) begin
                    restart = 1'b1;
                end else if (sample_valid) begin
                    accept = 1'b1;
                    if (sample_cnt == LAST_IDX) begin
                        last       = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (result_ack && start) begin
                    state_next = RUN;
                    restart    = 1'b1;
                end else begin
                    if (result_ack) begin
                        state_next = IDLE;
                    end
                    if (sample_valid) begin
                        ovr_set = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sample and hit counters; cleared on every accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            hit_cnt    <= '0;
        end else if (restart) begin
            sample_cnt <= '0;
            hit_cnt    <= '0;
        end else if (accept) begin
            sample_cnt <= sample_cnt + 1'b1;
            hit_cnt    <= hit_total;
        end
    end

    // Result capture on the final sample of the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_hits <= '0;
            pi_q        <= '0;
        end else if (last) begin
            result_hits <= hit_total;
            pi_q        <= pi_next;
        end
    end

    // Sticky overrun flag for samples dropped outside RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (restart) begin
            overrun <= 1'b0;
        end else if (ovr_set) begin
            overrun <= 1'b1;
        end
    end

    // Status outputs decoded from the state register only
    always_comb begin
        busy         = (state == RUN);
        result_valid = (state == DONE);
    end

endmodule
